// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, lane widths, FSM states.
// The alignment helper is only referenced when LSU_ALIGN_CHECK_EN is defined.
package lsu_pkg;

  localparam logic [1:0] SizeByte    = 2'b00;
  localparam logic [1:0] SizeHalf    = 2'b01;
  localparam logic [1:0] SizeWord    = 2'b10;
  localparam logic [1:0] SizeIllegal = 2'b11;

  localparam int unsigned ByteW = 8;
  localparam int unsigned HalfW = 16;
  localparam int unsigned WordW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStoreRd,
    StStoreWr
  } lsu_state_e;

  function automatic logic lsu_bad_access(logic [1:0] size, logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SizeHalf:    bad = off[0];
      SizeWord:    bad = (off != 2'b00);
      SizeIllegal: bad = 1'b1;
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request and data-memory signals of the load/store unit.
// slave: the unit itself; master: pipeline plus memory side.
interface load_store_unit_if;
  logic        Req;
  logic        Wr;
  logic [1:0]  Size;
  logic        Signed;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic        Ready;
  logic        Done;
  logic        Err;
  logic [31:0] RdData;
  logic        DMWE;
  logic [31:0] DMA;
  logic [31:0] DMWD;
  logic [31:0] DMRD;

  modport slave (
    input  Req, Wr, Size, Signed, Addr, WrData, DMRD,
    output Ready, Done, Err, RdData, DMWE, DMA, DMWD
  );

  modport master (
    output Req, Wr, Size, Signed, Addr, WrData, DMRD,
    input  Ready, Done, Err, RdData, DMWE, DMA, DMWD
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extract/extend for loads, lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]       size,
  input  logic             sign_ext,
  input  logic [1:0]       byte_off,
  input  logic [WordW-1:0] rd_word,
  input  logic [WordW-1:0] wr_data,
  output logic [WordW-1:0] load_data,
  output logic [WordW-1:0] merge_data
);

  logic [ByteW-1:0] byte_lane;
  logic [HalfW-1:0] half_lane;

  always_comb begin
    byte_lane = rd_word[{byte_off, 3'b000} +: ByteW];
    half_lane = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

    load_data  = rd_word;
    merge_data = wr_data;
    case (size)
      SizeByte: begin
        load_data  = {{(WordW - ByteW){sign_ext & byte_lane[ByteW-1]}}, byte_lane};
        merge_data = rd_word;
        merge_data[{byte_off, 3'b000} +: ByteW] = wr_data[ByteW-1:0];
      end
      SizeHalf: begin
        load_data  = {{(WordW - HalfW){sign_ext & half_lane[HalfW-1]}}, half_lane};
        merge_data = rd_word;
        merge_data[{byte_off[1], 4'b0000} +: HalfW] = wr_data[HalfW-1:0];
      end
      default: begin
        load_data  = rd_word;
        merge_data = wr_data;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a word-addressed data memory; sub-word stores use read-modify-write.
// Define LSU_ALIGN_CHECK_EN to flag misaligned and illegal-size requests with Err.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned AW = 9
) (
  input logic               Clk,
  input logic               Rst_n,
  load_store_unit_if.slave  bus
);

  lsu_state_e      state_q, state_d;
  logic [1:0]      size_q;
  logic            signed_q;
  logic [AW+1:0]   addr_q;
  logic [WordW-1:0] wdata_q, merge_q, merge_d;
  logic [WordW-1:0] rd_data_q, rd_data_d;
  logic            done_q, done_d, err_q, err_d;

  logic            accept;
  logic [1:0]      req_size;
  logic            req_err;
  logic [WordW-1:0] load_data, merge_data;

  // Address bits above the memory range are ignored by design.
  logic unused_addr;
  assign unused_addr = ^bus.Addr[31:AW+2];

`ifdef LSU_ALIGN_CHECK_EN
  assign req_size = bus.Size;
  assign req_err  = lsu_bad_access(bus.Size, bus.Addr[1:0]);
`else
  assign req_size = (bus.Size == SizeIllegal) ? SizeWord : bus.Size;
  assign req_err  = 1'b0;
`endif

  assign accept = bus.Req && (state_q == StIdle);

  lsu_lane_align u_lane_align (
    .size       (size_q),
    .sign_ext   (signed_q),
    .byte_off   (addr_q[1:0]),
    .rd_word    (bus.DMRD),
    .wr_data    (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_data_d = rd_data_q;
    merge_d   = merge_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Req) begin
          if (req_err) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (!bus.Wr) begin
            state_d = StLoad;
          end else if (req_size == SizeWord) begin
            state_d = StStoreWr;
          end else begin
            state_d = StStoreRd;
          end
        end
      end
      StLoad: begin
        rd_data_d = load_data;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      StStoreRd: begin
        merge_d = merge_data;
        state_d = StStoreWr;
      end
      StStoreWr: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= StIdle;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      size_q    <= SizeByte;
      signed_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      merge_q   <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      merge_q   <= merge_d;
      if (accept) begin
        size_q   <= req_size;
        signed_q <= bus.Signed;
        addr_q   <= bus.Addr[AW+1:0];
        wdata_q  <= bus.WrData;
      end
    end
  end

  assign bus.Ready  = (state_q == StIdle);
  assign bus.Done   = done_q;
  assign bus.Err    = err_q;
  assign bus.RdData = rd_data_q;
  assign bus.DMWE   = (state_q == StStoreWr);
  assign bus.DMA    = (state_q != StIdle) ? {{(32 - AW){1'b0}}, addr_q[AW+1:2]} : 32'd0;
  assign bus.DMWD   = (state_q != StStoreWr) ? 32'd0 :
                      (size_q == SizeWord)   ? wdata_q : merge_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  load_store_unit_if bus ();

  load_store_unit #(.AW(9)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:511];
  logic        bd_we = 1'b0;
  logic [8:0]  bd_idx = '0;
  logic [31:0] bd_val = '0;
  int          writes = 0;
  int          checks = 0;
  int          failures = 0;
  int          w0;

  assign bus.DMRD = mem[bus.DMA[8:0]];

  always @(posedge Clk) begin
    if (bus.DMWE) begin
      mem[bus.DMA[8:0]] <= bus.DMWD;
      writes <= writes + 1;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_val;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [8:0] idx, input logic [31:0] val);
    bd_we = 1'b1; bd_idx = idx; bd_val = val;
    tick();
    bd_we = 1'b0;
  endtask

  // Drives a request, clocks the accept edge, drops Req; returns in cycle 1.
  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.Req = 1'b1; bus.Wr = wr; bus.Size = size; bus.Signed = sgn;
    bus.Addr = addr; bus.WrData = wdata;
    tick();
    bus.Req = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Req = 1'b0; bus.Wr = 1'b0; bus.Size = SizeByte; bus.Signed = 1'b0;
    bus.Addr = '0; bus.WrData = '0;
    tick();
    tick();
    check("rst_ready", bus.Ready, 1);
    check("rst_done", bus.Done, 0);
    check("rst_err", bus.Err, 0);
    check("rst_rddata", bus.RdData, 0);
    check("rst_dmwe", bus.DMWE, 0);
    check("rst_dma", bus.DMA, 0);
    check("rst_dmwd", bus.DMWD, 0);
    Rst_n = 1'b1;
    tick();

    // Byte load, zero-extend
    poke(9'd5, 32'h1122_3344);
    issue(1'b0, SizeByte, 1'b0, 32'h15, 32'h0);
    check("lb_c1_done", bus.Done, 0);
    check("lb_c1_ready", bus.Ready, 0);
    check("lb_c1_dma", bus.DMA, 32'd5);
    tick();
    check("lb_c2_done", bus.Done, 1);
    check("lb_c2_err", bus.Err, 0);
    check("lb_c2_data", bus.RdData, 32'h0000_0033);
    check("lb_c2_ready", bus.Ready, 1);
    tick();
    check("lb_c3_done", bus.Done, 0);

    // Halfword loads, signed then unsigned
    poke(9'd5, 32'h80FF_0000);
    issue(1'b0, SizeHalf, 1'b1, 32'h16, 32'h0);
    tick();
    check("lhs_data", bus.RdData, 32'hFFFF_80FF);
    check("lhs_done", bus.Done, 1);
    issue(1'b0, SizeHalf, 1'b0, 32'h16, 32'h0);
    tick();
    check("lhu_data", bus.RdData, 32'h0000_80FF);

    // Byte store via read-modify-write
    poke(9'd5, 32'h1122_3344);
    w0 = writes;
    issue(1'b1, SizeByte, 1'b0, 32'h14, 32'h1234_56AB);
    check("sb_c1_dmwe", bus.DMWE, 0);
    check("sb_c1_dmwd", bus.DMWD, 0);
    tick();
    check("sb_c2_dmwe", bus.DMWE, 1);
    check("sb_c2_dma", bus.DMA, 32'd5);
    check("sb_c2_dmwd", bus.DMWD, 32'h1122_33AB);
    check("sb_c2_done", bus.Done, 0);
    tick();
    check("sb_c3_done", bus.Done, 1);
    check("sb_c3_dmwe", bus.DMWE, 0);
    check("sb_mem", mem[5], 32'h1122_33AB);
    check("sb_writes", writes - w0, 1);

    // Halfword store into the upper lane
    issue(1'b1, SizeHalf, 1'b0, 32'h16, 32'h7777_BEEF);
    tick();
    check("sh_dmwd", bus.DMWD, 32'hBEEF_33AB);
    tick();
    check("sh_mem", mem[5], 32'hBEEF_33AB);

    // Word store, then back-to-back load in the Done cycle
    issue(1'b1, SizeWord, 1'b0, 32'h20, 32'hDEAD_BEEF);
    check("sw_c1_dmwe", bus.DMWE, 1);
    check("sw_c1_dma", bus.DMA, 32'd8);
    check("sw_c1_dmwd", bus.DMWD, 32'hDEAD_BEEF);
    tick();
    check("sw_c2_done", bus.Done, 1);
    check("sw_c2_ready", bus.Ready, 1);
    issue(1'b0, SizeWord, 1'b1, 32'h20, 32'h0);
    check("lw_c1_done", bus.Done, 0);
    check("lw_c1_ready", bus.Ready, 0);
    tick();
    check("lw_c2_done", bus.Done, 1);
    check("lw_c2_data", bus.RdData, 32'hDEAD_BEEF);

    // Misaligned halfword load
    poke(9'd4, 32'hCAFE_1234);
    w0 = writes;
    issue(1'b0, SizeHalf, 1'b0, 32'h13, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    check("mis_c1_done", bus.Done, 1);
    check("mis_c1_err", bus.Err, 1);
    check("mis_c1_ready", bus.Ready, 1);
    check("mis_c1_dmwe", bus.DMWE, 0);
    check("mis_c1_data", bus.RdData, 32'hDEAD_BEEF);
    tick();
    check("mis_c2_done", bus.Done, 0);
    check("mis_c2_err", bus.Err, 0);
    // Illegal size store must not touch memory
    issue(1'b1, SizeIllegal, 1'b0, 32'h20, 32'h0BAD_0BAD);
    check("ill_err", bus.Err, 1);
    check("ill_done", bus.Done, 1);
    tick();
    check("mis_writes", writes - w0, 0);
    check("ill_mem", mem[8], 32'hDEAD_BEEF);
`else
    check("mis_c1_done", bus.Done, 0);
    tick();
    check("mis_c2_done", bus.Done, 1);
    check("mis_c2_err", bus.Err, 0);
    check("mis_c2_data", bus.RdData, 32'h0000_CAFE);
    // Size 11 behaves as a word store
    issue(1'b1, SizeIllegal, 1'b0, 32'h20, 32'h0BAD_0BAD);
    check("ill_dmwe", bus.DMWE, 1);
    tick();
    check("ill_err", bus.Err, 0);
    check("ill_mem", mem[8], 32'h0BAD_0BAD);
`endif

    // Reset during STORE_RD aborts without writing
    poke(9'd6, 32'h5566_7788);
    w0 = writes;
    issue(1'b1, SizeByte, 1'b0, 32'h18, 32'h99);
    check("rrd_c1_ready", bus.Ready, 0);
    Rst_n = 1'b0;
    tick();
    check("rrd_ready", bus.Ready, 1);
    check("rrd_done", bus.Done, 0);
    check("rrd_dmwe", bus.DMWE, 0);
    check("rrd_rddata", bus.RdData, 0);
    Rst_n = 1'b1;
    tick();
    check("rrd_done2", bus.Done, 0);
    check("rrd_writes", writes - w0, 0);
    check("rrd_mem", mem[6], 32'h5566_7788);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
